mini_i_cache_dm: RTL and testbench

MINI_I_CACHE_DM -- requirements
Module: mini_i_cache_dm

---
 rtl/mini_i_cache_dm.sv | 173 +++++++++++++++++
 tb/tb_mini_i_cache_dm.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_i_cache_dm.sv
// Direct-mapped instruction cache. Misses refill the whole line one word at a
// time over a simple valid/ready bus, starting at word 0. A flush request is
// remembered until the controller is next in IDLE, where it is applied.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | waiting for a fetch request; applies a pending flush first
// LOOKUP      | compares the tag and valid bit of the indexed line
// REFILL_ADDR | presents one refill word address on the bus
// REFILL_DATA | waits for that refill word and writes it into the line
// RESP        | holds the fetched word until the requester takes it
// FLUSH       | clears every valid bit (one cycle)
module mini_i_cache_dm #(
  parameter int data_width     = 32,
  parameter int addr_width     = 32,
  parameter int num_lines      = 16,
  parameter int words_per_line = 4,
  parameter int count_width    = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ir_addr_valid,
  output logic                   ir_addr_ready,
  input  logic [addr_width-1:0]  ir_addr,
  output logic                   ir_data_valid,
  input  logic                   ir_data_ready,
  output logic [data_width-1:0]  ir_data,
  output logic                   bus_ir_addr_valid,
  input  logic                   bus_ir_addr_ready,
  output logic [addr_width-1:0]  bus_ir_addr,
  input  logic                   bus_ir_data_valid,
  output logic                   bus_ir_data_ready,
  input  logic [data_width-1:0]  bus_ir_data,
  input  logic                   flush,
  output logic [count_width-1:0] hit_count,
  output logic [count_width-1:0] miss_count
);

  localparam int OB = $clog2(data_width / 8);
  localparam int WB = $clog2(words_per_line);
  localparam int LB = $clog2(num_lines);
  localparam int TW = addr_width - OB - WB - LB;
  localparam logic [addr_width-1:0] LINE_MASK =
    addr_width'(words_per_line * (data_width / 8) - 1);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL_ADDR, REFILL_DATA, RESP, FLUSH
  } state_e;

  state_e state_q, state_d;

  logic [addr_width-1:0]  addr_q;
  logic [WB-1:0]          cnt_q;
  logic [num_lines-1:0]   valid_q;
  logic [TW-1:0]          tag_q [num_lines];
  logic [data_width-1:0]  mem_q [num_lines*words_per_line];
  logic [data_width-1:0]  rdata_q;
  logic                   flush_pend_q;
  logic [count_width-1:0] hit_q;
  logic [count_width-1:0] miss_q;

  logic [WB-1:0] req_word;
  logic [LB-1:0] req_line;
  logic [TW-1:0] req_tag;
  logic          hit;
  logic          last_word;
  logic          accept;
  logic          refill_wr;

  assign req_word  = addr_q[OB +: WB];
  assign req_line  = addr_q[OB+WB +: LB];
  assign req_tag   = addr_q[OB+WB+LB +: TW];
  assign hit       = valid_q[req_line] && (tag_q[req_line] == req_tag);
  assign last_word = (cnt_q == WB'(words_per_line - 1));
  assign accept    = ir_addr_valid && ir_addr_ready;
  assign refill_wr = (state_q == REFILL_DATA) && bus_ir_data_valid;

  // Refill word address: base of the requested line plus the word offset.
  assign bus_ir_addr = (addr_q & ~LINE_MASK) |
                       ({{(addr_width-WB){1'b0}}, cnt_q} << OB);
  assign ir_data     = rdata_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a flush (pending or arriving now) beats a new request.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush_pend_q || flush) state_d = FLUSH;
        else if (ir_addr_valid)    state_d = LOOKUP;
      end
      LOOKUP:      state_d = hit ? RESP : REFILL_ADDR;
      REFILL_ADDR: if (bus_ir_addr_ready) state_d = REFILL_DATA;
      REFILL_DATA: begin
        if (bus_ir_data_valid) state_d = last_word ? RESP : REFILL_ADDR;
      end
      RESP:        if (ir_data_ready) state_d = IDLE;
      FLUSH:       state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    ir_addr_ready     = 1'b0;
    ir_data_valid     = 1'b0;
    bus_ir_addr_valid = 1'b0;
    bus_ir_data_ready = 1'b0;
    case (state_q)
      IDLE:        ir_addr_ready     = !flush_pend_q && !flush;
      REFILL_ADDR: bus_ir_addr_valid = 1'b1;
      REFILL_DATA: bus_ir_data_ready = 1'b1;
      RESP:        ir_data_valid     = 1'b1;
      default:     ;
    endcase
  end

  // Control datapath: request address, word counter, valid bits, stats.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      cnt_q        <= '0;
      valid_q      <= '0;
      rdata_q      <= '0;
      flush_pend_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      if (accept) addr_q <= ir_addr;

      if (state_q == FLUSH) flush_pend_q <= flush;
      else if (flush)       flush_pend_q <= 1'b1;

      case (state_q)
        LOOKUP: begin
          if (hit) begin
            rdata_q <= mem_q[{req_line, req_word}];
            if (hit_q != '1) hit_q <= hit_q + 1'b1;
          end else begin
            cnt_q             <= '0;
            valid_q[req_line] <= 1'b0;
            if (miss_q != '1) miss_q <= miss_q + 1'b1;
          end
        end
        REFILL_DATA: begin
          if (bus_ir_data_valid) begin
            if (cnt_q == req_word) rdata_q <= bus_ir_data;
            if (last_word) valid_q[req_line] <= 1'b1;
            else           cnt_q <= cnt_q + 1'b1;
          end
        end
        FLUSH:   valid_q <= '0;
        default: ;
      endcase
    end
  end

  // Line storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clock) begin
    if (refill_wr) begin
      mem_q[{req_line, cnt_q}] <= bus_ir_data;
      if (last_word) tag_q[req_line] <= req_tag;
    end
  end

endmodule

// File: tb/tb_mini_i_cache_dm.sv
// Bench for mini_i_cache_dm: directed scenarios plus randomized fetches
// against a line-level cache model. A second instance with narrow counters
// runs in lockstep to exercise counter saturation.
module tb_mini_i_cache_dm;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ir_addr_valid = 1'b0;
  logic        ir_addr_ready;
  logic [31:0] ir_addr = '0;
  logic        ir_data_valid;
  logic        ir_data_ready = 1'b0;
  logic [31:0] ir_data;
  logic        bus_ir_addr_valid;
  logic        bus_ir_addr_ready = 1'b0;
  logic [31:0] bus_ir_addr;
  logic        bus_ir_data_valid = 1'b0;
  logic        bus_ir_data_ready;
  logic [31:0] bus_ir_data = '0;
  logic        flush = 1'b0;
  logic [15:0] hit_count, miss_count;

  logic        s_ir_addr_ready, s_ir_data_valid, s_bus_ir_addr_valid, s_bus_ir_data_ready;
  logic [31:0] s_ir_data, s_bus_ir_addr;
  logic [3:0]  s_hit_count, s_miss_count;

  mini_i_cache_dm dut (
    .clock(clock), .reset_n(reset_n),
    .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
    .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
    .bus_ir_addr_valid(bus_ir_addr_valid), .bus_ir_addr_ready(bus_ir_addr_ready),
    .bus_ir_addr(bus_ir_addr),
    .bus_ir_data_valid(bus_ir_data_valid), .bus_ir_data_ready(bus_ir_data_ready),
    .bus_ir_data(bus_ir_data),
    .flush(flush), .hit_count(hit_count), .miss_count(miss_count)
  );

  mini_i_cache_dm #(.count_width(4)) dut_s (
    .clock(clock), .reset_n(reset_n),
    .ir_addr_valid(ir_addr_valid), .ir_addr_ready(s_ir_addr_ready), .ir_addr(ir_addr),
    .ir_data_valid(s_ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(s_ir_data),
    .bus_ir_addr_valid(s_bus_ir_addr_valid), .bus_ir_addr_ready(bus_ir_addr_ready),
    .bus_ir_addr(s_bus_ir_addr),
    .bus_ir_data_valid(bus_ir_data_valid), .bus_ir_data_ready(s_bus_ir_data_ready),
    .bus_ir_data(bus_ir_data),
    .flush(flush), .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model: per-line valid/tag/words, bus memory = f(address, key).
  logic        mv [16];
  logic [23:0] mt [16];
  logic [31:0] md [16][4];
  int          hits_m = 0;
  int          misses_m = 0;
  logic [31:0] bus_key = '0;
  logic [31:0] bus_log [$];

  function automatic logic [31:0] reply(input logic [31:0] a);
    return ((a >> 2) + 32'hF0) ^ bus_key;
  endfunction

  function automatic int sat(input int x, input int m);
    return (x > m) ? m : x;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  task automatic model_access(input logic [31:0] a, output logic hit, output logic [31:0] d);
    int l, w;
    logic [23:0] t;
    l = int'(a[7:4]);
    w = int'(a[3:2]);
    t = a[31:8];
    hit = mv[l] && (mt[l] == t);
    if (hit) hits_m++;
    else begin
      misses_m++;
      for (int j = 0; j < 4; j++) md[l][j] = reply({a[31:4], 4'(j * 4)});
      mv[l] = 1'b1;
      mt[l] = t;
    end
    d = md[l][w];
  endtask

  // Drives one fetch end to end and plays the refill bus.
  task automatic fetch(input logic [31:0] a, input int resp_stall, input int addr_stall,
                       input int flush_at, input int reset_at,
                       output logic [31:0] data, output int nbus, output int lat,
                       output logic stable_ok, output logic timeout);
    int k, ast, rs;
    logic [31:0] cur, held;
    logic in_addr;
    nbus = 0; lat = -1; stable_ok = 1'b1; timeout = 1'b0; data = '0;
    bus_log.delete();
    in_addr = 1'b0; cur = '0; held = '0; ast = 0; rs = 0;
    @(negedge clock);
    flush = 1'b0;
    ir_addr_valid = 1'b1;
    ir_addr = a;
    #1;
    k = 0;
    while (ir_addr_ready !== 1'b1) begin
      @(negedge clock);
      #1;
      k++;
      if (k > 20) begin
        timeout = 1'b1;
        ir_addr_valid = 1'b0;
        return;
      end
    end
    @(posedge clock);
    k = 0;
    forever begin
      @(negedge clock);
      k++;
      ir_addr_valid = 1'b0;
      flush = 1'b0;
      bus_ir_addr_ready = 1'b0;
      bus_ir_data_valid = 1'b0;
      ir_data_ready = 1'b0;
      if (k == reset_at) begin
        reset_n = 1'b0;
        return;
      end
      if (k == flush_at) flush = 1'b1;
      if (bus_ir_addr_valid) begin
        if (!in_addr) begin
          in_addr = 1'b1;
          cur = bus_ir_addr;
          bus_log.push_back(cur);
          nbus++;
          ast = addr_stall;
        end else if (bus_ir_addr !== cur) stable_ok = 1'b0;
        if (ast > 0) ast--;
        else begin
          bus_ir_addr_ready = 1'b1;
          in_addr = 1'b0;
        end
      end
      if (bus_ir_data_ready) begin
        bus_ir_data_valid = 1'b1;
        bus_ir_data = reply(cur);
      end
      if (ir_data_valid) begin
        if (lat < 0) begin
          lat = k;
          held = ir_data;
          rs = resp_stall;
        end else if (ir_data !== held || ir_addr_ready !== 1'b0) stable_ok = 1'b0;
        if (rs > 0) rs--;
        else begin
          ir_data_ready = 1'b1;
          data = ir_data;
          @(posedge clock);
          #1;
          ir_data_ready = 1'b0;
          flush = 1'b0;
          return;
        end
      end
      if (k > 200) begin
        timeout = 1'b1;
        flush = 1'b0;
        return;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (ir_data_valid !== 1'b0) begin bad++; $display("FAIL rst_ir_data_valid got=%b want=0", ir_data_valid); end
    total++; if (bus_ir_addr_valid !== 1'b0) begin bad++; $display("FAIL rst_bus_addr_valid got=%b want=0", bus_ir_addr_valid); end
    total++; if (bus_ir_data_ready !== 1'b0) begin bad++; $display("FAIL rst_bus_data_ready got=%b want=0", bus_ir_data_ready); end
    total++; if (bus_ir_addr !== 32'h0) begin bad++; $display("FAIL rst_bus_addr got=%h want=0", bus_ir_addr); end
    total++; if (ir_data !== 32'h0) begin bad++; $display("FAIL rst_ir_data got=%h want=0", ir_data); end
    total++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin bad++; $display("FAIL rst_counters got=%0d/%0d want=0/0", hit_count, miss_count); end
    total++; if (s_ir_data !== 32'h0 || s_bus_ir_addr !== 32'h0) begin bad++; $display("FAIL rst_small_outputs got=%h/%h want=0/0", s_ir_data, s_bus_ir_addr); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    total++; if (ir_addr_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after_release got=%b want=1", ir_addr_ready); end
    total++; if (s_ir_addr_ready !== 1'b1 || s_ir_data_valid !== 1'b0 || s_bus_ir_addr_valid !== 1'b0 || s_bus_ir_data_ready !== 1'b0) begin
      bad++; $display("FAIL rst_small_handshake got=%b%b%b%b want=1000", s_ir_addr_ready, s_ir_data_valid, s_bus_ir_addr_valid, s_bus_ir_data_ready);
    end
  endtask

  task automatic test_cold_miss();
    logic [31:0] d, e; int nb, lat; logic ok, to, h;
    logic [31:0] exp_addr [4];
    exp_addr[0] = 32'h40; exp_addr[1] = 32'h44; exp_addr[2] = 32'h48; exp_addr[3] = 32'h4C;
    model_access(32'h48, h, e);
    fetch(32'h48, 0, 0, -1, -1, d, nb, lat, ok, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL cold_timeout got=%b want=0", to); end
    total++; if (nb != 4) begin bad++; $display("FAIL cold_bus_count got=%0d want=4", nb); end
    for (int i = 0; i < 4 && i < nb; i++) begin
      total++; if (bus_log[i] !== exp_addr[i]) begin bad++; $display("FAIL cold_bus_addr%0d got=%h want=%h", i, bus_log[i], exp_addr[i]); end
    end
    total++; if (d !== 32'h102) begin bad++; $display("FAIL cold_data got=%h want=00000102", d); end
    total++; if (miss_count !== 16'd1) begin bad++; $display("FAIL cold_miss_count got=%0d want=1", miss_count); end
  endtask

  task automatic test_hit();
    logic [31:0] d, e; int nb, lat; logic ok, to, h;
    model_access(32'h4C, h, e);
    fetch(32'h4C, 0, 0, -1, -1, d, nb, lat, ok, to);
    total++; if (d !== 32'h103) begin bad++; $display("FAIL hit_data got=%h want=00000103", d); end
    total++; if (lat != 2) begin bad++; $display("FAIL hit_latency got=%0d want=2", lat); end
    total++; if (nb != 0) begin bad++; $display("FAIL hit_bus_count got=%0d want=0", nb); end
    total++; if (hit_count !== 16'd1) begin bad++; $display("FAIL hit_count got=%0d want=1", hit_count); end
  endtask

  task automatic test_conflict();
    logic [31:0] d, e; int nb, lat; logic ok, to, h;
    model_access(32'h148, h, e);
    fetch(32'h148, 0, 0, -1, -1, d, nb, lat, ok, to);
    total++; if (nb != 4) begin bad++; $display("FAIL conflict_bus_count got=%0d want=4", nb); end
    total++; if (nb > 0 && bus_log[0] !== 32'h140) begin bad++; $display("FAIL conflict_base got=%h want=00000140", bus_log[0]); end
    total++; if (d !== 32'h142) begin bad++; $display("FAIL conflict_data got=%h want=00000142", d); end
    model_access(32'h48, h, e);
    fetch(32'h48, 0, 0, -1, -1, d, nb, lat, ok, to);
    total++; if (nb != 4) begin bad++; $display("FAIL conflict_remiss_bus got=%0d want=4", nb); end
    total++; if (d !== 32'h102) begin bad++; $display("FAIL conflict_remiss_data got=%h want=00000102", d); end
    total++; if (miss_count !== 16'd3) begin bad++; $display("FAIL conflict_miss_count got=%0d want=3", miss_count); end
  endtask

  task automatic test_flush();
    logic [31:0] d, e; int nb, lat; logic ok, to, h;
    @(negedge clock); flush = 1'b1;
    @(negedge clock); flush = 1'b0;
    model_clear();
    model_access(32'h48, h, e);
    fetch(32'h48, 0, 0, -1, -1, d, nb, lat, ok, to);
    total++; if (nb != 4) begin bad++; $display("FAIL flush_then_miss got=%0d want=4", nb); end
    // Flush and a request in the same idle cycle: flush first, then accept.
    @(negedge clock);
    flush = 1'b1; ir_addr_valid = 1'b1; ir_addr = 32'h48;
    #1;
    total++; if (ir_addr_ready !== 1'b0) begin bad++; $display("FAIL flush_vs_req_ready got=%b want=0", ir_addr_ready); end
    model_clear();
    model_access(32'h48, h, e);
    fetch(32'h48, 0, 0, -1, -1, d, nb, lat, ok, to);
    total++; if (to !== 1'b0 || nb != 4) begin bad++; $display("FAIL flush_vs_req_miss got=%0d timeout=%b want=4", nb, to); end
    // Flush mid-refill: refill completes, line dropped afterwards.
    model_access(32'h88, h, e);
    fetch(32'h88, 0, 0, 3, -1, d, nb, lat, ok, to);
    model_clear();
    total++; if (nb != 4 || d !== 32'h112) begin bad++; $display("FAIL flush_mid_refill got=%0d/%h want=4/00000112", nb, d); end
    model_access(32'h88, h, e);
    fetch(32'h88, 0, 0, -1, -1, d, nb, lat, ok, to);
    total++; if (nb != 4) begin bad++; $display("FAIL flush_mid_refill_remiss got=%0d want=4", nb); end
  endtask

  task automatic test_stall();
    logic [31:0] d, e; int nb, lat; logic ok, to, h;
    model_access(32'h2C4, h, e);
    fetch(32'h2C4, 5, 3, -1, -1, d, nb, lat, ok, to);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_miss_stable got=%b want=1", ok); end
    total++; if (d !== e || nb != 4) begin bad++; $display("FAIL stall_miss_data got=%h/%0d want=%h/4", d, nb, e); end
    model_access(32'h2C8, h, e);
    fetch(32'h2C8, 5, 0, -1, -1, d, nb, lat, ok, to);
    total++; if (ok !== 1'b1 || lat != 2 || d !== e) begin bad++; $display("FAIL stall_hit got=%b/%0d/%h want=1/2/%h", ok, lat, d, e); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] d, e; int nb, lat; logic ok, to, h;
    fetch(32'h3D4, 0, 0, -1, 6, d, nb, lat, ok, to);
    #1;
    total++; if (nb != 2) begin bad++; $display("FAIL rmid_words_before_reset got=%0d want=2", nb); end
    total++; if (bus_ir_addr_valid !== 1'b0 || bus_ir_data_ready !== 1'b0 || ir_data_valid !== 1'b0 || bus_ir_addr !== 32'h0 || ir_data !== 32'h0) begin
      bad++; $display("FAIL rmid_outputs got=%b%b%b %h %h want=000 0 0", bus_ir_addr_valid, bus_ir_data_ready, ir_data_valid, bus_ir_addr, ir_data);
    end
    total++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin bad++; $display("FAIL rmid_counters got=%0d/%0d want=0/0", hit_count, miss_count); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    total++; if (ir_addr_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", ir_addr_ready); end
    model_clear(); hits_m = 0; misses_m = 0;
    model_access(32'h3D4, h, e);
    fetch(32'h3D4, 0, 0, -1, -1, d, nb, lat, ok, to);
    total++; if (nb != 4 || (nb > 0 && bus_log[0] !== 32'h3D0)) begin bad++; $display("FAIL rmid_remiss got=%0d want=4", nb); end
    total++; if (d !== e || miss_count !== 16'd1) begin bad++; $display("FAIL rmid_remiss_data got=%h/%0d want=%h/1", d, miss_count, e); end
  endtask

  task automatic test_saturation();
    logic [31:0] d, e; int nb, lat; logic ok, to, h;
    for (int i = 0; i < 19; i++) begin
      model_access(32'h3D8, h, e);
      fetch(32'h3D8, 0, 0, -1, -1, d, nb, lat, ok, to);
    end
    total++; if (s_hit_count !== 4'(sat(hits_m, 15))) begin bad++; $display("FAIL sat_hit_small got=%0d want=%0d", s_hit_count, sat(hits_m, 15)); end
    total++; if (hit_count !== 16'(sat(hits_m, 65535))) begin bad++; $display("FAIL sat_hit_wide got=%0d want=%0d", hit_count, hits_m); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, e; int nb, lat, fa; logic ok, to, h;
    for (int it = 0; it < 40; it++) begin
      bus_key = $urandom;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) | (32'($urandom_range(0, 3)) << 2);
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : -1;
      model_access(a, h, e);
      fetch(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), fa, -1, d, nb, lat, ok, to);
      if (fa > 0) model_clear();
      total++; if (d !== e || to !== 1'b0) begin bad++; $display("FAIL rand_data it=%0d addr=%h got=%h want=%h", it, a, d, e); end
      total++; if (nb != (h ? 0 : 4) || ok !== 1'b1) begin bad++; $display("FAIL rand_bus it=%0d addr=%h got=%0d stable=%b want=%0d", it, a, nb, ok, h ? 0 : 4); end
    end
    total++; if (hit_count !== 16'(sat(hits_m, 65535)) || miss_count !== 16'(sat(misses_m, 65535))) begin
      bad++; $display("FAIL rand_counters got=%0d/%0d want=%0d/%0d", hit_count, miss_count, hits_m, misses_m);
    end
    total++; if (s_miss_count !== 4'(sat(misses_m, 15))) begin bad++; $display("FAIL rand_small_miss got=%0d want=%0d", s_miss_count, sat(misses_m, 15)); end
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clock);
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_stall();
    test_reset_mid_refill();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
